times_table_sequencer: RTL and testbench
========================================

TIMES_TABLE_SEQUENCER -- requirements
Module: times_table_sequencer

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, cycles from an enabled memory read to valid result; legal values 1..2.
REQ-002 SHALL have ports clk input 1 (rising-edge system clock) and rst_n input 1 (reset, asynchronous, active-low); one clock, no other clock or reset.
REQ-003 SHALL have port start input 1: a pulse that begins a sweep of all 64 table entries.
REQ-004 SHALL have port pause input 1: while high, no new memory reads are issued.
REQ-005 SHALL have ports a output 3 and b output 3: operands driven to the downstream times-table memory.
REQ-006 SHALL have port enable output 1: memory read enable.
REQ-007 SHALL have port result input 6: product returned by the memory.
REQ-008 SHALL have port res_valid output 1: the res_* outputs hold a captured entry this cycle.
REQ-009 SHALL have ports res_a output 3, res_b output 3 and res_data output 6: operands and product of the captured entry.
REQ-010 SHALL have ports busy output 1, done output 1 (1-cycle pulse) and sum output 12 (running total of captured products).

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DRAIN and DONE, with IDLE as the reset state.
REQ-012 SHALL, in IDLE on start=1, clear sum, set {a,b}=0 and enter RUN on the next edge.
REQ-013 SHALL ignore start in every state other than IDLE.
REQ-014 SHALL, in RUN with pause=0, drive enable=1 and issue address {a,b}; {a,b} increments by 1 each cycle, with a as the major field (a=a+1 when b wraps 7->0).
REQ-015 SHALL, in RUN with pause=1, drive enable=0 and hold {a,b}; any number of pause cycles is legal.
REQ-016 SHALL, when the read of {7,7} is issued, enter DRAIN on the next edge and drive enable=0 in DRAIN.
REQ-017 SHALL track each issued read with a READ_LATENCY-deep tag pipeline (valid, a, b) that shifts every cycle; a cycle with enable=0 inserts valid=0.
REQ-018 SHALL, when a tag with valid=1 exits the pipeline, register res_valid=1, res_a and res_b from the tag, res_data=result, and sum=sum+result, all in the same cycle.
REQ-019 SHALL produce exactly 64 res_valid pulses per sweep, in address order, each exactly READ_LATENCY+1 cycles after its read is issued (1 cycle memory latency + 1 capture register).
REQ-020 SHALL leave DRAIN for DONE once the tag pipeline is empty and the last capture is registered.
REQ-021 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-022 SHALL drive busy=1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-023 SHALL hold sum after done until the next accepted start; sum is 12 bits and cannot overflow (max 64*63=4032).
REQ-024 SHALL take no action on pause in IDLE, DRAIN or DONE.

Reset
REQ-025 SHALL, on rst_n=0, immediately force state=IDLE, a=b=0, enable=0, all tag valids=0, res_valid=0, res_a=res_b=res_data=0, busy=0, done=0, sum=0, and err=0 when present.
REQ-026 SHALL, when reset is asserted mid-sweep, abandon the sweep with no further res_valid or done, and accept start on the first edge after rst_n=1.

Configuration
REQ-027 SHALL, with macro TTSEQ_SELF_CHECK_EN defined, add output err (1 bit, sticky): set on any capture where res_data != res_a*res_b, cleared only by reset or by an accepted start.
REQ-028 SHALL, without TTSEQ_SELF_CHECK_EN, have no err port and no comparator logic; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover: reset, start pulse, correct table, READ_LATENCY=1 -> 64 res_valid, first {0,0,0} at cycle 3 after start, last {7,7,49}, sum=784, one done pulse, busy low after.
REQ-030 SHALL cover: pause high for 5 cycles starting at address 20 -> enable low 5 cycles, no entry skipped or duplicated, sum=784, done delayed 5 cycles.
REQ-031 SHALL cover: start re-pulsed at address 30 -> ignored, sequence continues, sum=784.
REQ-032 SHALL cover: rst_n low at address 40 -> all outputs 0 asynchronously, no done; new start gives a full sweep with sum=784.
REQ-033 SHALL cover: READ_LATENCY=2 -> each capture 3 cycles after its issue, 64 captures, sum=784.
REQ-034 SHALL cover: TTSEQ_SELF_CHECK_EN defined, memory entry {3,5} corrupted to 14 -> err rises on capture of {3,5} and stays high; sum=783.

Source files
------------

// File: rtl/times_table_sequencer.sv
// times_table_sequencer: sweeps all 64 {a,b} entries of a downstream
// times-table memory, captures each product with its operands and keeps a
// running sum of the captured products.
// Optional build macro TTSEQ_SELF_CHECK_EN adds a sticky err output that
// flags any captured product that differs from res_a*res_b.
module times_table_sequencer #(
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned OP_W   = 3,
  localparam int unsigned ADDR_W = 2 * OP_W,
  localparam int unsigned DATA_W = 6,
  localparam int unsigned SUM_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  output logic [OP_W-1:0]   a,
  output logic [OP_W-1:0]   b,
  output logic              enable,
  input  logic [DATA_W-1:0] result,
  output logic              res_valid,
  output logic [OP_W-1:0]   res_a,
  output logic [OP_W-1:0]   res_b,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum
`ifdef TTSEQ_SELF_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Tracks one outstanding read while the memory works on it.
  typedef struct packed {
    logic            v;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } tag_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((1 << ADDR_W) - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  tag_t              tag_q [READ_LATENCY];
  tag_t              tag_out;
  logic              issue;
  logic              start_acc;
  logic              last_issue;
  logic              tags_empty;

  // Operand address is a single counter with a as the major field.
  assign {a, b}     = addr;
  assign issue      = (state == RUN) && !pause;
  assign enable     = issue;
  assign start_acc  = (state == IDLE) && start;
  assign last_issue = issue && (addr == LAST_ADDR);
  assign tag_out    = tag_q[READ_LATENCY-1];

  // Pipeline is empty once no tag in flight is marked valid.
  always_comb begin
    tags_empty = 1'b1;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      if (tag_q[i].v) tags_empty = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      DRAIN:   if (tags_empty) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
    end
  end

  // Address counter: cleared on an accepted start, advances per issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (start_acc) begin
      addr <= '0;
    end else if (issue) begin
      addr <= addr + ADDR_W'(1);
    end
  end

  // Tag pipeline shifts every cycle; idle cycles insert an invalid tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{v: issue, a: a, b: b};
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Capture register: operands from the exiting tag, product from memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= tag_out.v;
      if (tag_out.v) begin
        res_a    <= tag_out.a;
        res_b    <= tag_out.b;
        res_data <= result;
      end
    end
  end

  // Running total; a new sweep starts from zero, otherwise held after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (start_acc) begin
      sum <= '0;
    end else if (tag_out.v) begin
      sum <= sum + SUM_W'(result);
    end
  end

`ifdef TTSEQ_SELF_CHECK_EN
  // Sticky flag for any captured product that disagrees with a*b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start_acc) begin
      err <= 1'b0;
    end else if (tag_out.v && (result != (DATA_W'(tag_out.a) * DATA_W'(tag_out.b)))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_times_table_sequencer.sv
// Bench for times_table_sequencer: runs READ_LATENCY=1 and =2 instances side
// by side on the same start/pause stimulus, each fed by its own memory model,
// and compares every cycle against a sweep-level reference model.
// Define TTSEQ_SELF_CHECK_EN to also exercise the err output.
module tb_times_table_sequencer;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              pause;
  logic [1:0][2:0]   a_o;
  logic [1:0][2:0]   b_o;
  logic [1:0]        en_o;
  logic [1:0][5:0]   res_i;
  logic [1:0]        rv_o;
  logic [1:0][2:0]   ra_o;
  logic [1:0][2:0]   rb_o;
  logic [1:0][5:0]   rd_o;
  logic [1:0]        busy_o;
  logic [1:0]        done_o;
  logic [1:0][11:0]  sum_o;
`ifdef TTSEQ_SELF_CHECK_EN
  logic [1:0]        err_o;
`endif

  logic [5:0] tbl [64];
  logic [5:0] r1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state per instance (index 0: latency 1, index 1: latency 2).
  bit active    [2];
  int n_iss     [2];
  int ptr       [2];
  int done_edge [2];
  int s_edge    [2];
  int msum      [2];
  bit merr      [2];
  int cap_edge  [2][64];

  // Sweep observations taken from the DUT.
  int obs_rv        [2];
  int obs_done      [2];
  int obs_first     [2];
  int obs_done_edge [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    times_table_sequencer #(.READ_LATENCY(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .pause     (pause),
      .a         (a_o[g]),
      .b         (b_o[g]),
      .enable    (en_o[g]),
      .result    (res_i[g]),
      .res_valid (rv_o[g]),
      .res_a     (ra_o[g]),
      .res_b     (rb_o[g]),
      .res_data  (rd_o[g]),
      .busy      (busy_o[g]),
      .done      (done_o[g]),
      .sum       (sum_o[g])
`ifdef TTSEQ_SELF_CHECK_EN
      ,
      .err       (err_o[g])
`endif
    );
  end

  always #5 clk = ~clk;

  // Times-table memories: one-cycle and two-cycle read latency.
  always @(posedge clk) begin
    if (en_o[0]) res_i[0] <= tbl[{a_o[0], b_o[0]}];
    if (en_o[1]) r1 <= tbl[{a_o[1], b_o[1]}];
    res_i[1] <= r1;
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic bit model_busy(input int i, input int edge_n);
    return active[i] && !(done_edge[i] >= 0 && edge_n > done_edge[i]);
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s L%0d outputs", tag, lat(i)),
            longint'({rv_o[i], ra_o[i], rb_o[i], rd_o[i], busy_o[i], done_o[i],
                      sum_o[i], en_o[i], a_o[i], b_o[i]}), 0);
`ifdef TTSEQ_SELF_CHECK_EN
      check($sformatf("%s L%0d err", tag, lat(i)), err_o[i], 0);
`endif
    end
  endtask

  // One clock: drive inputs, check issue side mid-cycle, advance model, check capture side.
  task automatic step(input bit st, input bit pz);
    bit run_c;
    bit busy_prev;
    bit e_rv;
    int e_k;
    int L;
    start = st;
    pause = pz;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      run_c = active[i] && (n_iss[i] < 64);
      check($sformatf("enable L%0d", lat(i)), en_o[i], run_c && !pz);
      if (run_c) check($sformatf("addr L%0d", lat(i)), {a_o[i], b_o[i]}, n_iss[i]);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      L = lat(i);
      busy_prev = model_busy(i, cyc - 1);
      if (active[i] && n_iss[i] < 64 && !pz) begin
        cap_edge[i][n_iss[i]] = cyc;
        n_iss[i]++;
        if (n_iss[i] == 64) done_edge[i] = cyc + L + 1;
      end
      e_rv = 1'b0;
      e_k  = 0;
      if (active[i] && ptr[i] < n_iss[i] && cap_edge[i][ptr[i]] + L == cyc) begin
        e_rv = 1'b1;
        e_k  = ptr[i];
        msum[i] += int'(tbl[e_k]);
        if (int'(tbl[e_k]) != (e_k / 8) * (e_k % 8)) merr[i] = 1'b1;
        ptr[i]++;
      end
      if (!busy_prev && st) begin
        active[i]    = 1'b1;
        n_iss[i]     = 0;
        ptr[i]       = 0;
        done_edge[i] = -1;
        s_edge[i]    = cyc;
        msum[i]      = 0;
        merr[i]      = 1'b0;
      end
      check($sformatf("res_valid L%0d", L), rv_o[i], e_rv);
      if (e_rv) begin
        check($sformatf("res_a L%0d", L), ra_o[i], e_k / 8);
        check($sformatf("res_b L%0d", L), rb_o[i], e_k % 8);
        check($sformatf("res_data L%0d", L), rd_o[i], tbl[e_k]);
      end
      check($sformatf("busy L%0d", L), busy_o[i], model_busy(i, cyc));
      check($sformatf("done L%0d", L), done_o[i], done_edge[i] == cyc);
      check($sformatf("sum L%0d", L), sum_o[i], msum[i]);
`ifdef TTSEQ_SELF_CHECK_EN
      check($sformatf("err L%0d", L), err_o[i], merr[i]);
`endif
      if (rv_o[i]) begin
        obs_rv[i]++;
        if (obs_first[i] < 0) obs_first[i] = cyc;
      end
      if (done_o[i]) begin
        obs_done[i]++;
        obs_done_edge[i] = cyc;
      end
    end
  endtask

  // Asynchronous reset asserted mid-cycle, released away from the clock edge.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 check_zero("async reset");
    for (int i = 0; i < 2; i++) begin
      active[i]    = 1'b0;
      done_edge[i] = -1;
      msum[i]      = 0;
      merr[i]      = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #2 rst_n = 1'b1;
  endtask

  // mode 0 plain, 1 pause x5 at address 20, 2 start re-pulse at 30,
  // 3 reset at address 40, 4 random pause/start.
  task automatic run_sweep(input int mode, input int exp_total);
    int  pleft   = 0;
    bit  pdone   = 1'b0;
    bit  rpulsed = 1'b0;
    int  npause  = 0;
    int  budget  = 0;
    bit  st;
    bit  pz;
    for (int i = 0; i < 2; i++) begin
      obs_rv[i]        = 0;
      obs_done[i]      = 0;
      obs_first[i]     = -1;
      obs_done_edge[i] = -1;
    end
    step(1'b1, (mode == 4) ? 1'($urandom_range(1)) : 1'b0);
    while ((model_busy(0, cyc) || model_busy(1, cyc)) && budget < 300) begin
      st = 1'b0;
      pz = 1'b0;
      case (mode)
        1: begin
          if (n_iss[0] == 20 && !pdone) begin
            pleft = 5;
            pdone = 1'b1;
          end
          if (pleft > 0) begin
            pz = 1'b1;
            pleft--;
            npause++;
          end
        end
        2: if (n_iss[0] == 30 && !rpulsed) begin
          st = 1'b1;
          rpulsed = 1'b1;
        end
        3: if (n_iss[0] == 40) begin
          do_reset();
          return;
        end
        4: begin
          pz = ($urandom_range(3) == 0);
          st = (n_iss[0] < 64) && ($urandom_range(15) == 0);
        end
        default: ;
      endcase
      step(st, pz);
      budget++;
    end
    check($sformatf("sweep %0d finished in budget", mode), budget < 300, 1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("sweep %0d captures L%0d", mode, lat(i)), obs_rv[i], 64);
      check($sformatf("sweep %0d done pulses L%0d", mode, lat(i)), obs_done[i], 1);
      check($sformatf("sweep %0d total L%0d", mode, lat(i)), sum_o[i], exp_total);
      if (mode != 4) begin
        check($sformatf("sweep %0d first capture delay L%0d", mode, lat(i)),
              obs_first[i] - s_edge[i], lat(i) + 1);
        check($sformatf("sweep %0d done delay L%0d", mode, lat(i)),
              obs_done_edge[i] - s_edge[i], 65 + lat(i) + npause);
      end
`ifdef TTSEQ_SELF_CHECK_EN
      check($sformatf("sweep %0d err L%0d", mode, lat(i)), err_o[i], exp_total != 784);
`endif
    end
    repeat (3) step(1'b0, 1'($urandom_range(1)));
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    r1    = '0;
    res_i = '0;
    for (int k = 0; k < 64; k++) tbl[k] = 6'((k / 8) * (k % 8));
    for (int i = 0; i < 2; i++) begin
      active[i]    = 1'b0;
      n_iss[i]     = 0;
      ptr[i]       = 0;
      done_edge[i] = -1;
      s_edge[i]    = 0;
      msum[i]      = 0;
      merr[i]      = 1'b0;
    end
    #2 check_zero("power-on reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b1);

    run_sweep(0, 784);
    run_sweep(1, 784);
    run_sweep(2, 784);
    run_sweep(3, 0);
    repeat (4) step(1'b0, 1'b0);
    run_sweep(0, 784);
    tbl[29] = 6'd14;
    run_sweep(4, 783);
    tbl[29] = 6'd15;
    run_sweep(4, 784);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
